pipe_register: RTL and testbench
================================

// Module: pipe_register
// PURPOSE
//  Parametrised elastic pipeline register: DEPTH stages of W-bit data with a valid/ready handshake.
//  Sits between CPU datapath units (e.g. ALU operand latch -> execute) where the plain per-clock
//  operand register cannot stall or flush.
//  Bubble-collapsing: an empty stage accepts data even while downstream is stalled.
//  Full throughput is 1 word/cycle.
// PARAMETERS
//  W      32  data width in bits (>=1)
//  DEPTH  2   number of register stages (>=1; 0 is illegal, elaboration $error)
// PORTS
//  clock      in   1                    rising-edge clock
//  reset      in   1                    asynchronous, active-high reset
//  in_valid   in   1                    upstream word present on in_data
//  in_ready   out  1                    pipe accepts in_data this cycle
//  in_data    in   W                    upstream data
//  out_valid  out  1                    last stage holds a valid word
//  out_ready  in   1                    downstream accepts out_data this cycle
//  out_data   out  W                    last-stage data
//  flush      in   1                    synchronous discard of all stored words
//  occupancy  out  $clog2(DEPTH+1)      number of valid stages (0..DEPTH)
//  stall_cnt  out  16                   only with PIPE_STALL_CNT_EN; see CONFIGURATION
// BEHAVIOUR
//  - Stage state: valid[k], data[k], with k=0..DEPTH-1 and stage DEPTH-1 driving out_*.
//  - Ready chain (combinational):
//      rdy[DEPTH-1] = !valid[DEPTH-1] | out_ready
//      rdy[k]       = !valid[k] | rdy[k+1]
//  - Input ready: in_ready = rdy[0] & !flush.
//  - Load rule: stage k loads from stage k-1 (stage 0 loads from in_*) when rdy[k] is high.
//      data[k] is written only when the source is valid.
//      valid[k] <= source valid.
//  - A transfer occurs on an edge where valid & ready are both high; there is no other accept condition.
//  - Latency: with out_ready held at 1, in_data appears on out_data exactly DEPTH cycles after acceptance.
//  - Full: all valid bits set and out_ready=0 -> in_ready=0, and contents are held unchanged.
//  - Full with out_ready=1: the pipe shifts, in_ready=1, and a simultaneous push+pop keeps occupancy at DEPTH.
//  - Empty: out_valid=0; out_data holds the last value (don't-care).
//  - Flush=1 at an edge: all valid[k] <= 0.
//      The input is not accepted (in_ready=0 that cycle).
//      out_valid still reflects the pre-flush state during the flush cycle.
//      Downstream may take that word; it is then dropped from the pipe.
//  - Reset vs flush: reset dominates flush; flush dominates load.
//  - Reset (async, any time incl. mid-transfer): valid[*]=0, data[*]=0, so out_valid=0, out_data=0,
//    occupancy=0, stall_cnt=0. in_ready=1 once reset is released (0 while flush is high).
//  - occupancy = popcount(valid), combinational from registered bits.
//  - Protocol rule: upstream must hold in_data stable while in_valid & !in_ready.
// CONFIGURATION
//  Macro: PIPE_STALL_CNT_EN.
//  - Defined: adds output stall_cnt[15:0], which counts cycles with out_valid & !out_ready.
//      Saturates at 16'hFFFF.
//      Cleared only by reset; flush does not clear it.
//  - Undefined: the stall_cnt port and its counter logic are absent; all other behaviour is identical.
// STRUCTURE
//  - Package cpu_pipe_pkg: STALL_CNT_W=16 and function clog2_p1(n) for the occupancy width.
//  - Sub-module pipe_stage: one stage, holding valid/data registers, the load mux and its local rdy term.
//  - pipe_register instantiates DEPTH copies in a generate loop.
//  - The top level also holds the occupancy popcount and the optional stall counter.
// TESTING
//  1. Reset: assert reset mid-stream with DEPTH=3 holding 3 words.
//     -> Same cycle (async): out_valid=0, occupancy=0, out_data=0.
//  2. Streaming: W=32, DEPTH=3, out_ready=1, push 0x1,0x2,0x3 on consecutive cycles.
//     -> out_data=0x1 exactly 3 cycles after its accept, then 0x2 and 0x3 on consecutive cycles.
//  3. Backpressure: out_ready=0, push 4 words into DEPTH=3.
//     -> occupancy=3, in_ready=0 after the 3rd accept.
//     -> Raising out_ready drains 0x1,0x2,0x3 in order, with the 4th accepted the same cycle 0x1 pops.
//  4. Bubble collapse: DEPTH=3 with only stage 2 valid, out_ready=0.
//     -> in_ready=1, and two further pushes are accepted (occupancy 1->3).
//  5. Flush: occupancy=2, assert flush with in_valid=1.
//     -> in_ready=0 that cycle; next cycle occupancy=0, out_valid=0, and the input word is dropped.
//  6. PIPE_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 10 cycles.
//     -> stall_cnt=10. Flush -> still 10. Reset -> 0.
//     -> Force the counter to 16'hFFFE, stall 3 cycles -> 16'hFFFF.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared constants and helpers for the elastic CPU pipeline register.
`default_nettype none

package cpu_pipe_pkg;

  localparam int STALL_CNT_W = 16;

  typedef logic [STALL_CNT_W-1:0] stall_cnt_t;

  // Bits needed to hold the values 0..n (never less than one bit).
  function automatic int clog2_p1(input int n);
    int r;
    r = 0;
    while ((1 << r) < (n + 1)) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage.sv
// One elastic stage: valid/data registers, load mux and the local ready term.
`default_nettype none

module pipe_stage #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         src_valid,
  input  logic [W-1:0] src_data,
  input  logic         down_rdy,
  output logic         rdy,
  output logic         valid,
  output logic [W-1:0] data
);

  // An empty stage can always take a word, even while downstream is stalled.
  assign rdy = !valid | down_rdy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (rdy) begin
      valid <= src_valid;
      if (src_valid) begin
        data <= src_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_register.sv
// DEPTH-stage valid/ready pipeline register with flush and occupancy count.
// Optional PIPE_STALL_CNT_EN adds a saturating output-stall cycle counter.
`default_nettype none

module pipe_register
  import cpu_pipe_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W-1:0]                 in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [W-1:0]                 out_data,
  input  logic                         flush,
  output logic [clog2_p1(DEPTH)-1:0]   occupancy
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0]       stall_cnt
`endif
);

  localparam int OCC_W = clog2_p1(DEPTH);

  if (DEPTH < 1) begin : g_depth_check
    $error("pipe_register: DEPTH must be at least 1");
  end

  logic [DEPTH-1:0] valid_vec;
  logic [W-1:0]     data_s [DEPTH];

  // Each stage keeps its ready term in its own scope so the chain is not one shared vector.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic         rdy_here;
    logic         down_rdy;
    logic         src_valid;
    logic [W-1:0] src_data;

    if (k == DEPTH - 1) begin : g_last
      assign down_rdy = out_ready;
    end else begin : g_mid
      assign down_rdy = g_stage[k+1].rdy_here;
    end

    if (k == 0) begin : g_first
      assign src_valid = in_valid;
      assign src_data  = in_data;
    end else begin : g_chain
      assign src_valid = valid_vec[k-1];
      assign src_data  = data_s[k-1];
    end

    pipe_stage #(.W(W)) u_stage (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .src_valid (src_valid),
      .src_data  (src_data),
      .down_rdy  (down_rdy),
      .rdy       (rdy_here),
      .valid     (valid_vec[k]),
      .data      (data_s[k])
    );
  end

  assign in_ready  = g_stage[0].rdy_here & !flush;
  assign out_valid = valid_vec[DEPTH-1];
  assign out_data  = data_s[DEPTH-1];

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + OCC_W'(valid_vec[k]);
    end
  end

`ifdef PIPE_STALL_CNT_EN
  // Flush deliberately leaves the counter alone; only reset clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_register.sv
// Directed self-checking bench for pipe_register (W=32, DEPTH=3).
`default_nettype none

module tb_pipe_register;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        flush;
  logic [1:0]  occupancy;
`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  pipe_register #(.W(32), .DEPTH(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .occupancy (occupancy)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clock);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    nxt(); nxt();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_occupancy", {30'b0, occupancy}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    reset = 1'b0;
    #1 chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Streaming: three words back to back, out_ready held high.
    nxt();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h1;
    nxt();
    chk("lat_early1", {31'b0, out_valid}, 32'd0);
    in_data = 32'h2;
    nxt();
    chk("lat_early2", {31'b0, out_valid}, 32'd0);
    in_data = 32'h3;
    nxt();
    in_valid = 1'b0;
    chk("stream_v1", {31'b0, out_valid}, 32'd1);
    chk("stream_d1", out_data, 32'h1);
    nxt();
    chk("stream_d2", out_data, 32'h2);
    nxt();
    chk("stream_d3", out_data, 32'h3);
    chk("stream_v3", {31'b0, out_valid}, 32'd1);
    nxt();
    chk("stream_empty", {31'b0, out_valid}, 32'd0);
    chk("stream_occ0", {30'b0, occupancy}, 32'd0);

    // Backpressure: fill, block the 4th word, then drain.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h1;
    nxt(); in_data = 32'h2;
    nxt(); in_data = 32'h3;
    nxt(); in_data = 32'h4;
    #1;
    chk("bp_occ3", {30'b0, occupancy}, 32'd3);
    chk("bp_in_ready0", {31'b0, in_ready}, 32'd0);
    chk("bp_head", out_data, 32'h1);
    nxt();
    chk("bp_hold_occ", {30'b0, occupancy}, 32'd3);
    chk("bp_hold_head", out_data, 32'h1);
    out_ready = 1'b1;
    #1 chk("bp_in_ready1", {31'b0, in_ready}, 32'd1);
    nxt();
    in_valid = 1'b0;
    chk("bp_pushpop_occ", {30'b0, occupancy}, 32'd3);
    chk("bp_drain2", out_data, 32'h2);
    nxt();
    chk("bp_drain3", out_data, 32'h3);
    chk("bp_occ2", {30'b0, occupancy}, 32'd2);
    nxt();
    chk("bp_drain4", out_data, 32'h4);
    nxt();
    chk("bp_empty", {30'b0, occupancy}, 32'd0);

    // Bubble collapse: only the last stage holds a word while stalled.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA;
    nxt(); in_valid = 1'b0;
    nxt(); nxt();
    chk("bub_occ1", {30'b0, occupancy}, 32'd1);
    chk("bub_head", out_data, 32'hA);
    in_valid = 1'b1; in_data = 32'hB;
    #1 chk("bub_rdy_a", {31'b0, in_ready}, 32'd1);
    nxt();
    chk("bub_occ2", {30'b0, occupancy}, 32'd2);
    in_data = 32'hC;
    #1 chk("bub_rdy_b", {31'b0, in_ready}, 32'd1);
    nxt();
    in_valid = 1'b0;
    chk("bub_occ3", {30'b0, occupancy}, 32'd3);
    chk("bub_head_kept", out_data, 32'hA);
    #1 chk("bub_full_rdy", {31'b0, in_ready}, 32'd0);

    // Flush with occupancy 2 and an incoming word.
    out_ready = 1'b1;
    nxt();
    out_ready = 1'b0;
    chk("fl_occ2", {30'b0, occupancy}, 32'd2);
    chk("fl_head", out_data, 32'hB);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hD;
    #1;
    chk("fl_in_ready0", {31'b0, in_ready}, 32'd0);
    chk("fl_pre_valid", {31'b0, out_valid}, 32'd1);
    nxt();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_occ0", {30'b0, occupancy}, 32'd0);
    chk("fl_out_valid0", {31'b0, out_valid}, 32'd0);
    nxt(); nxt(); nxt();
    chk("fl_dropped", {30'b0, occupancy}, 32'd0);

    // Asynchronous reset in the middle of a full pipe.
    in_valid = 1'b1; in_data = 32'hE;
    nxt(); in_data = 32'hF;
    nxt(); in_data = 32'h10;
    nxt(); in_valid = 1'b0;
    chk("ar_full", {30'b0, occupancy}, 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("ar_out_valid", {31'b0, out_valid}, 32'd0);
    chk("ar_occ", {30'b0, occupancy}, 32'd0);
    chk("ar_out_data", out_data, 32'd0);
    nxt();
    reset = 1'b0;
    #1 chk("ar_in_ready", {31'b0, in_ready}, 32'd1);

`ifdef PIPE_STALL_CNT_EN
    nxt();
    chk("sc_reset0", {16'b0, stall_cnt}, 32'd0);
    in_valid = 1'b1; in_data = 32'h55;
    nxt(); in_valid = 1'b0;
    nxt(); nxt();
    chk("sc_head", {31'b0, out_valid}, 32'd1);
    chk("sc_start", {16'b0, stall_cnt}, 32'd0);
    repeat (10) nxt();
    chk("sc_ten", {16'b0, stall_cnt}, 32'd10);
    // Downstream takes the word during the flush cycle, so no stall is counted.
    flush = 1'b1; out_ready = 1'b1;
    nxt();
    flush = 1'b0; out_ready = 1'b0;
    chk("sc_after_flush", {16'b0, stall_cnt}, 32'd10);
    reset = 1'b1;
    #1 chk("sc_after_reset", {16'b0, stall_cnt}, 32'd0);
    nxt();
    reset = 1'b0;
    in_valid = 1'b1; in_data = 32'h66;
    nxt(); in_valid = 1'b0;
    nxt(); nxt();
    repeat (65534) nxt();
    chk("sc_fffe", {16'b0, stall_cnt}, 32'hFFFE);
    repeat (3) nxt();
    chk("sc_sat", {16'b0, stall_cnt}, 32'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
